// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
package uart_pkg;

    localparam int UART_DATA_BITS           = 8;
    localparam int UART_DEFAULT_CLK_PER_BIT = 434;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLK_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_tick #(
    parameter int CLK_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter with a one-byte holding register.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = UART_DEFAULT_CLK_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       new_tx_data,
    output logic       tx_busy,
    output logic       tx,
    output logic       tx_done,
    output logic [2:0] dbg_state
);

    // Handshake: a byte is taken on any rising edge where new_tx_data=1 and
    // tx_busy=0; requests seen while tx_busy=1 are dropped silently.

    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_state_t               state, state_nx;
    logic [UART_DATA_BITS-1:0] hold_data;
    logic                      hold_valid;
    logic [UART_DATA_BITS-1:0] shift;
    logic [2:0]                bit_idx;
    logic                      load;
    logic                      shift_en;
    logic                      idx_clr;
    logic                      done_nx;
    logic                      baud_clear;
    logic                      baud_tick;
`ifdef UART_TX_PARITY_EN
    logic                      parity_q;
`endif

    uart_baud_tick #(
        .CLK_PER_BIT(CLK_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (baud_clear),
        .tick  (baud_tick)
    );

    assign tx_busy   = hold_valid;
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            hold_data  <= '0;
            hold_valid <= 1'b0;
            shift      <= '0;
            bit_idx    <= '0;
            tx_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state   <= state_nx;
            tx_done <= done_nx;
            // Load and accept are mutually exclusive: load needs hold_valid=1.
            if (load) begin
                shift      <= hold_data;
                hold_valid <= 1'b0;
`ifdef UART_TX_PARITY_EN
                parity_q   <= ^hold_data;
`endif
            end else begin
                if (new_tx_data && !hold_valid) begin
                    hold_data  <= tx_data;
                    hold_valid <= 1'b1;
                end
                if (shift_en) begin
                    shift <= shift >> 1;
                end
            end
            if (idx_clr) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        load       = 1'b0;
        shift_en   = 1'b0;
        idx_clr    = 1'b0;
        done_nx    = 1'b0;
        baud_clear = 1'b0;
        case (state)
            IDLE: begin
                baud_clear = 1'b1;
                if (hold_valid) begin
                    load     = 1'b1;
                    state_nx = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    idx_clr  = 1'b1;
                    state_nx = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shift_en = 1'b1;
                    if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_tick) begin
                    state_nx = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_tick) begin
                    done_nx = 1'b1;
                    if (hold_valid) begin
                        load     = 1'b1;
                        state_nx = START;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        case (state)
            START:   tx = 1'b0;
            DATA:    tx = shift[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx = parity_q;
`endif
            default: tx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: cycle-level line waveform model with random traffic.
module tb_uart_tx_serializer;
    import uart_pkg::*;

    localparam int CPB = 4;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       new_tx_data;
    logic       tx_busy;
    logic       tx;
    logic       tx_done;
    logic [2:0] dbg_state;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    // Model: exp_q holds the expected tx level for every remaining cycle of the
    // frame on the line; m_hold/m_byte mirror the holding register contents.
    logic       exp_q[$];
    logic       m_hold;
    logic [7:0] m_byte;
    logic       m_done;

    uart_tx_serializer #(
        .CLK_PER_BIT(CPB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .new_tx_data (new_tx_data),
        .tx_busy     (tx_busy),
        .tx          (tx),
        .tx_done     (tx_done),
        .dbg_state   (dbg_state)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_level(input logic lvl);
        for (int i = 0; i < CPB; i++) exp_q.push_back(lvl);
    endtask

    task automatic push_frame(input logic [7:0] b);
        push_level(1'b0);
        for (int i = 0; i < 8; i++) push_level(b[i]);
`ifdef UART_TX_PARITY_EN
        push_level(^b);
`endif
        push_level(1'b1);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_hold = 1'b0;
        m_byte = 8'h00;
        m_done = 1'b0;
    endtask

    task automatic model_edge(input logic req, input logic [7:0] d);
        logic hold_pre;
        hold_pre = m_hold;
        m_done   = 1'b0;
        if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) m_done = 1'b1;
        end
        if (exp_q.size() == 0 && hold_pre) begin
            push_frame(m_byte);
            m_hold = 1'b0;
        end
        if (req && !hold_pre) begin
            m_hold = 1'b1;
            m_byte = d;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic exp_tx;
        exp_tx = (exp_q.size() > 0) ? exp_q[0] : 1'b1;
        check({tag, "_tx"},   32'(tx),      32'(exp_tx));
        check({tag, "_busy"}, 32'(tx_busy), 32'(m_hold));
        check({tag, "_done"}, 32'(tx_done), 32'(m_done));
    endtask

    // Driver: present inputs, advance one edge, update model, sample #1 later.
    task automatic step(input logic req, input logic [7:0] d, input string tag);
        new_tx_data = req;
        tx_data     = d;
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge(req, d);
        #1;
        if (tx_done) done_cnt++;
        check_outputs(tag);
        new_tx_data = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 2000 && (exp_q.size() > 0 || m_hold); i++) step(1'b0, 8'h00, tag);
        repeat (3) step(1'b0, 8'h00, tag);
        check({tag, "_drained_busy"}, 32'(tx_busy), 32'(0));
    endtask

    initial begin
        rst         = 1'b1;
        new_tx_data = 1'b0;
        tx_data     = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx",    32'(tx),        32'(1));
        check("rst_busy",  32'(tx_busy),   32'(0));
        check("rst_done",  32'(tx_done),   32'(0));
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;

        // Idle line
        repeat (100) step(1'b0, 8'h00, "idle");

        // Single frame 0x55
        done_cnt = 0;
        step(1'b1, 8'h55, "f55");
        drain("f55");
        check("f55_done_cnt", 32'(done_cnt), 32'(1));

        // 0xA3 then 0x0F as soon as busy drops, plus a dropped 0x11
        done_cnt = 0;
        step(1'b1, 8'hA3, "b2b");
        for (int i = 0; i < 20 && m_hold; i++) step(1'b0, 8'h00, "b2b");
        step(1'b1, 8'h0F, "b2b");
        step(1'b1, 8'h11, "drop");
        drain("b2b");
        check("b2b_done_cnt", 32'(done_cnt), 32'(2));

        // Reset during bit 3 of 0xFF with 0x5A held
        done_cnt = 0;
        step(1'b1, 8'hFF, "rstmid");
        step(1'b0, 8'h00, "rstmid");
        step(1'b1, 8'h5A, "rstmid");
        repeat (16) step(1'b0, 8'h00, "rstmid");
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("async_tx",   32'(tx),      32'(1));
        check("async_busy", 32'(tx_busy), 32'(0));
        step(1'b0, 8'h00, "inrst");
        rst = 1'b0;
        repeat (50) step(1'b0, 8'h00, "postrst");
        check("rstmid_done_cnt", 32'(done_cnt), 32'(0));
        step(1'b1, 8'h3C, "f3c");
        drain("f3c");

`ifdef UART_TX_PARITY_EN
        step(1'b1, 8'h07, "par07");
        drain("par07");
`endif

        // Random traffic, including requests made while busy
        for (int n = 0; n < 40; n++) begin
            int gap;
            gap = $urandom_range(0, 50);
            for (int g = 0; g < gap; g++) step(1'b0, 8'h00, "rand");
            step(1'b1, 8'($urandom_range(0, 255)), "rand");
        end
        drain("rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
